// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit adder split into CHUNK-bit slices, one registered slice per stage.
// Optional subtract port enabled by defining PIPELINED_ADDER_SUB_EN.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STAGES = WIDTH / CHUNK;

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic             adv;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

`ifdef PIPELINED_ADDER_SUB_EN
    // Subtract becomes a + ~b + 1 at the entry, so the inverted operand carries the mode downstream.
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             src_valid;
        logic             src_carry;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;

        logic [CHUNK:0]   slice_d;
        logic [WIDTH-1:0] sum_d;

        logic             valid_q;
        logic             carry_q;
        logic [WIDTH-1:0] opa_q;
        logic [WIDTH-1:0] opb_q;
        logic [WIDTH-1:0] sum_q;

        if (k == 0) begin : g_src_in
            assign src_valid = in_valid;
            assign src_carry = c_in;
            assign src_a     = a;
            assign src_b     = b_in;
            assign src_sum   = '0;
        end else begin : g_src_prev
            assign src_valid = g_stage[k-1].valid_q;
            assign src_carry = g_stage[k-1].carry_q;
            assign src_a     = g_stage[k-1].opa_q;
            assign src_b     = g_stage[k-1].opb_q;
            assign src_sum   = g_stage[k-1].sum_q;
        end

        assign slice_d = {1'b0, src_a[k*CHUNK +: CHUNK]}
                       + {1'b0, src_b[k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, src_carry};

        always_comb begin
            sum_d                     = src_sum;
            sum_d[k*CHUNK +: CHUNK]   = slice_d[CHUNK-1:0];
        end

        // Data only moves with a valid token, so bubbles never overwrite the last result.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                opa_q   <= '0;
                opb_q   <= '0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    carry_q <= slice_d[CHUNK];
                    opa_q   <= src_a;
                    opb_q   <= src_b;
                    sum_q   <= sum_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic unused_ops;
            assign unused_ops = ^{opa_q, opb_q};
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed and random checks of pipelined_adder against a queue reference model.
module tb_pipelined_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef PIPELINED_ADDER_SUB_EN
    logic        sub;
`endif

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [16:0] exp_q[$];
    logic [16:0] last_out = '0;
    logic [16:0] held = '0;
    bit          stalled = 0;
    bit          seen_valid = 0;
    bit          seen_ready = 0;
    int          run_len = 0;
    int          max_run = 0;
    int          n_out = 0;
    int          n_vld = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic cv, input logic sv);
        if (sv) return 17'h10000 + {1'b0, av} - {1'b0, bv};
        return {1'b0, av} + {1'b0, bv} + {16'b0, cv};
    endfunction

    task automatic tick(output bit in_x);
        logic s;
        @(negedge clk);
        seen_valid = (out_valid === 1'b1);
        seen_ready = (in_ready === 1'b1);
        in_x = 0;
        if (rst) begin
            exp_q.delete();
            stalled = 0;
            run_len = 0;
        end else begin
            if (stalled) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", {cout, sum}, held);
            end
            if (seen_valid) begin
                run_len++;
                n_vld++;
            end else begin
                run_len = 0;
            end
            if (run_len > max_run) max_run = run_len;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 1'b0);
                end else begin
                    chk("result", {cout, sum}, exp_q.pop_front());
                    last_out = {cout, sum};
                    n_out++;
                end
            end
            stalled = out_valid && !out_ready;
            held    = {cout, sum};
            if (in_valid && in_ready) begin
                s = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
                s = sub;
`endif
                exp_q.push_back(model(a, b, cin, s));
                in_x = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        bit x;
        int n;
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        n = 0;
        do begin
            tick(x);
            n++;
        end while (!x && n < 50);
        chk("accepted", x, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic latency(output int lat);
        bit x;
        lat = 0;
        do begin
            tick(x);
            lat++;
        end while (!seen_valid && lat < 20);
    endtask

    task automatic drain();
        bit x;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            tick(x);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        bit  x;
        int  lat;
        int  n0;
        int  v0;
        int  acc;
        int  cyc;
        bit  pending;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
        sub = 1'b0;
`endif
        // reset state
        tick(x);
        tick(x);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        // wrap-around and carry-in
        send(16'hFFFF, 16'h0001, 1'b0);
        latency(lat);
        chk("lat_wrap", lat, 4);
        chk("wrap_val", last_out, 17'h10000);
        send(16'h7FFF, 16'h0000, 1'b1);
        latency(lat);
        chk("lat_cin", lat, 4);
        chk("cin_val", last_out, 17'h08000);

        // back-to-back at full rate
        max_run = 0;
        n0 = n_out;
        for (int i = 1; i <= 8; i++) send(16'(i), 16'(16'h1000 * i), 1'b0);
        drain();
        chk("b2b_run", max_run, 8);
        chk("b2b_count", n_out - n0, 8);
        chk("b2b_last", last_out, 17'h08008);

        // backpressure on a full pipe
        n0 = n_out;
        for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
        out_ready = 1'b0;
        a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(x);
            chk("bp_in_ready", seen_ready, 1'b0);
            chk("bp_no_xfer", x, 1'b0);
        end
        out_ready = 1'b1;
        send(16'hA5A5, 16'h5A5A, 1'b1);
        drain();
        chk("bp_count", n_out - n0, 5);
        chk("bp_last", last_out, 17'h10000);

        // reset with operations in flight
        for (int i = 0; i < 3; i++) send(16'h1111 * 16'(i + 1), 16'h0F0F, 1'b0);
        rst = 1'b1;
        tick(x);
        rst = 1'b0;
        chk("mid_rst_in_ready", in_ready, 1'b1);
        v0 = n_vld;
        for (int i = 0; i < 8; i++) tick(x);
        chk("mid_rst_flushed", n_vld - v0, 0);
        send(16'h1234, 16'h4321, 1'b1);
        latency(lat);
        chk("lat_after_rst", lat, 4);
        chk("after_rst_val", last_out, 17'h05556);

`ifdef PIPELINED_ADDER_SUB_EN
        sub = 1'b1;
        send(16'h0005, 16'h0007, 1'b1);
        latency(lat);
        chk("sub_borrow", last_out, 17'h0FFFE);
        send(16'h0009, 16'h0002, 1'b0);
        latency(lat);
        chk("sub_noborrow", last_out, 17'h10007);
        sub = 1'b0;
`endif

        // random traffic with random backpressure
        acc = 0; cyc = 0; pending = 0;
        n0 = n_out;
        while (acc < 3000 && cyc < 20000) begin
            if (!pending) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                b   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                cin = 1'($urandom);
`ifdef PIPELINED_ADDER_SUB_EN
                sub = 1'($urandom);
`endif
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick(x);
            cyc++;
            if (x) acc++;
            pending = in_valid && !x;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("rand_accepted", acc, 3000);
        chk("rand_results", n_out - n0, 3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
